// File: rtl/fixed_clock_reset_sequencer.sv
// Purpose: sequences per-domain reset release in index order and services per-domain clock-gate handshakes.
// Latency: domain k leaves reset HOLD_CYCLES + k*GAP_CYCLES edges after entry; gate/ungate and re-reset entry take 1 cycle.
// Backpressure: none; req_reset and gate_req are sampled only in RUN and ignored while sequencing.
module fixed_clock_reset_sequencer #(
    parameter int NUM_OUT     = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_reset,
    input  logic [NUM_OUT-1:0] gate_req,
    output logic [NUM_OUT-1:0] out_reset,
    output logic [NUM_OUT-1:0] out_clock_en,
    output logic [NUM_OUT-1:0] gate_ack,
    output logic               seq_done,
    output logic               busy
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      idx_inc;
    logic [NUM_OUT-1:0] out_reset_d;
    logic [NUM_OUT-1:0] gate_ack_d;
    logic               seq_done_d;
    logic               busy_d;
    // Low on the first edge after power-on reset is released, so that edge acts
    // as the ASSERT entry edge exactly like a req_reset entry does.
    logic               armed_q;

    assign idx_inc = idx_q + IW'(1);

    // The enable is the registered ack inverted, so the two can never disagree.
    assign out_clock_en = ~gate_ack;

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_reset_d = out_reset;
        gate_ack_d  = gate_ack;

        case (state_q)
            ST_ASSERT: begin
                out_reset_d = '1;
                gate_ack_d  = '0;
                if (!armed_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    cnt_d          = '0;
                    idx_d          = '0;
                    out_reset_d[0] = 1'b0;
                    state_d        = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_inc;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (IW'(i) == idx_inc) begin
                            out_reset_d[i] = 1'b0;
                        end
                    end
                    if (idx_inc == IW'(NUM_OUT - 1)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                if (req_reset) begin
                    state_d     = ST_ASSERT;
                    cnt_d       = '0;
                    idx_d       = '0;
                    out_reset_d = '1;
                    gate_ack_d  = '0;
                end else begin
                    // Set on req&!ack, clear on !req&ack, hold otherwise: that is ack <= req.
                    gate_ack_d = gate_req;
                end
            end

            default: begin
                state_d     = ST_ASSERT;
                cnt_d       = '0;
                idx_d       = '0;
                out_reset_d = '1;
                gate_ack_d  = '0;
            end
        endcase

        seq_done_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            armed_q   <= 1'b0;
            out_reset <= '1;
            gate_ack  <= '0;
            seq_done  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            armed_q   <= 1'b1;
            out_reset <= out_reset_d;
            gate_ack  <= gate_ack_d;
            seq_done  <= seq_done_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fixed_clock_reset_sequencer.sv
// Purpose: directed check of the reset sequencer, default parameters plus a NUM_OUT=1/HOLD_CYCLES=1 instance.
// Latency: expectations are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_fixed_clock_reset_sequencer;

    logic       clock = 1'b0;
    logic       rst1  = 1'b0;
    logic       rreq1 = 1'b0;
    logic [1:0] greq1 = 2'b00;
    logic [1:0] orst1, oen1, ack1;
    logic       done1, busy1;

    logic       rst2  = 1'b0;
    logic       rreq2 = 1'b0;
    logic [0:0] greq2 = 1'b0;
    logic [0:0] orst2, oen2, ack2;
    logic       done2, busy2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    fixed_clock_reset_sequencer #(.NUM_OUT(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)) dut (
        .clock(clock), .reset(rst1), .req_reset(rreq1), .gate_req(greq1),
        .out_reset(orst1), .out_clock_en(oen1), .gate_ack(ack1),
        .seq_done(done1), .busy(busy1)
    );

    fixed_clock_reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .GAP_CYCLES(4)) dut1 (
        .clock(clock), .reset(rst2), .req_reset(rreq2), .gate_req(greq2),
        .out_reset(orst2), .out_clock_en(oen2), .gate_ack(ack2),
        .seq_done(done2), .busy(busy2)
    );

    typedef struct {
        int         n;
        logic       rst;
        logic       rreq;
        logic [1:0] greq;
        logic [1:0] e_rst;
        logic [1:0] e_en;
        logic [1:0] e_ack;
        logic       e_done;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic q, input logic [1:0] g,
                       input logic [1:0] er, input logic [1:0] ee, input logic [1:0] ea,
                       input logic d, input logic b);
        vec_t v;
        v.n = n; v.rst = r; v.rreq = q; v.greq = g;
        v.e_rst = er; v.e_en = ee; v.e_ack = ea; v.e_done = d; v.e_busy = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int cnt;

        // power-on: reset 3 cycles, then E0; domain 0 at E0+16, domain 1 at E0+20
        add( 3, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add(15, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 3, 1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        // gating domain 1 for 5 cycles, then domain 0, then both
        add( 1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0);
        add( 4, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        add( 1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0);
        add( 1, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
        // re-reset while gated; gating resumes one cycle after seq_done
        add( 1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add(14, 1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b11, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 4, 1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        add( 1, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        // reset mid-sequence at E0+18, then full restart with ignored inputs
        add( 1, 1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add(17, 1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 5, 1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b1, 2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 9, 1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b1, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b11, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b1, 2'b00, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1);
        add( 1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);

        #1;
        foreach (tbl[i]) begin
            rst1  = tbl[i].rst;
            rreq1 = tbl[i].rreq;
            greq1 = tbl[i].greq;
            tick(tbl[i].n);
            check($sformatf("v%0d out_reset", i),    32'(orst1), 32'(tbl[i].e_rst));
            check($sformatf("v%0d out_clock_en", i), 32'(oen1),  32'(tbl[i].e_en));
            check($sformatf("v%0d gate_ack", i),     32'(ack1),  32'(tbl[i].e_ack));
            check($sformatf("v%0d seq_done", i),     32'(done1), 32'(tbl[i].e_done));
            check($sformatf("v%0d busy", i),         32'(busy1), 32'(tbl[i].e_busy));
        end

        // bounded wait: re-reset from RUN must complete in exactly 20 edges
        rreq1 = 1'b1;
        tick(1);
        rreq1 = 1'b0;
        check("rereset entry busy", 32'(busy1), 32'd1);
        cnt = 0;
        while (!done1 && cnt < 100) begin
            tick(1);
            cnt++;
        end
        check("rereset edges to seq_done", 32'(cnt), 32'd20);
        check("rereset out_reset released", 32'(orst1), 32'd0);

        // single-domain, one-cycle hold instance
        rst2 = 1'b0;
        tick(2);
        check("n1 reset out_reset", 32'(orst2), 32'd1);
        check("n1 reset busy", 32'(busy2), 32'd1);
        rst2 = 1'b1;
        tick(1);
        check("n1 E0 out_reset", 32'(orst2), 32'd1);
        check("n1 E0 seq_done", 32'(done2), 32'd0);
        tick(1);
        check("n1 E0+1 out_reset", 32'(orst2), 32'd0);
        check("n1 E0+1 seq_done", 32'(done2), 32'd1);
        check("n1 E0+1 busy", 32'(busy2), 32'd0);
        greq2 = 1'b1;
        tick(1);
        check("n1 gate ack", 32'(ack2), 32'd1);
        check("n1 gate en", 32'(oen2), 32'd0);
        rreq2 = 1'b1;
        tick(1);
        rreq2 = 1'b0;
        check("n1 rereset out_reset", 32'(orst2), 32'd1);
        check("n1 rereset ack", 32'(ack2), 32'd0);
        check("n1 rereset en", 32'(oen2), 32'd1);
        tick(1);
        check("n1 rereset release", 32'(orst2), 32'd0);
        check("n1 rereset done", 32'(done2), 32'd1);
        tick(1);
        check("n1 regate ack", 32'(ack2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
